// File: rtl/of_key_builder.sv
// Per-port flow key builder: parses an Ethernet/IPv4 header, builds the
// 116-bit lookup key, runs the req/ack lookup handshake and reports a decision.
module of_key_builder #(
  parameter logic [3:0] INGRESS_PORT = 4'h1,
  parameter logic [7:0] TIMEOUT      = 8'd32
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         rx_dv,
  input  logic [7:0]   rx_data,
  output logic         of_lookup_req,
  output logic [115:0] of_lookup_data,
  input  logic         of_lookup_ack,
  input  logic         of_lookup_err,
  input  logic [3:0]   of_lookup_fwd_port,
  output logic         res_valid,
  output logic [3:0]   res_fwd_port,
  output logic         res_drop,
  output logic         res_timeout,
  output logic [15:0]  drop_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PARSE = 2'd1;
  localparam logic [1:0] S_REQ   = 2'd2;
  localparam logic [1:0] S_SKIP  = 2'd3;

  logic [1:0] state;
  logic [5:0] byte_cnt;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_nxt;
  logic       rx_dv_q;
  logic       hdr_bad;

  assign tmo_nxt = tmo_cnt + 8'd1;

  // Only the ethertype and IP version are qualified; everything else is taken as-is.
  assign hdr_bad = ((byte_cnt == 6'd12) && (rx_data != 8'h08)) ||
                   ((byte_cnt == 6'd13) && (rx_data != 8'h00)) ||
                   ((byte_cnt == 6'd14) && (rx_data[7:4] != 4'h4));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= S_IDLE;
      byte_cnt       <= 6'd0;
      tmo_cnt        <= 8'd0;
      rx_dv_q        <= 1'b0;
      of_lookup_req  <= 1'b0;
      of_lookup_data <= '0;
      res_valid      <= 1'b0;
      res_fwd_port   <= 4'd0;
      res_drop       <= 1'b0;
      res_timeout    <= 1'b0;
      drop_cnt       <= 16'd0;
    end else begin
      rx_dv_q                  <= rx_dv;
      res_valid                <= 1'b0;
      res_fwd_port             <= 4'd0;
      res_drop                 <= 1'b0;
      res_timeout              <= 1'b0;
      of_lookup_data[115:112]  <= INGRESS_PORT;
      if (rx_dv && (byte_cnt != 6'd63)) byte_cnt <= byte_cnt + 6'd1;

      case (state)
        S_IDLE: begin
          tmo_cnt  <= 8'd0;
          // byte 0 (first dst MAC byte) is consumed here; it is not part of the key
          byte_cnt <= rx_dv ? 6'd1 : 6'd0;
          if (rx_dv) state <= S_PARSE;
        end

        S_PARSE: begin
          if (!rx_dv) begin
            res_valid <= 1'b1;
            res_drop  <= 1'b1;
            state     <= S_IDLE;
          end else begin
            if ((byte_cnt >= 6'd6) && (byte_cnt <= 6'd11))
              of_lookup_data[111:64] <= {of_lookup_data[103:64], rx_data};
            if ((byte_cnt >= 6'd26) && (byte_cnt <= 6'd29))
              of_lookup_data[63:32] <= {of_lookup_data[55:32], rx_data};
            if ((byte_cnt >= 6'd30) && (byte_cnt <= 6'd33))
              of_lookup_data[31:0] <= {of_lookup_data[23:0], rx_data};

            if (hdr_bad) begin
              res_valid <= 1'b1;
              res_drop  <= 1'b1;
              state     <= S_SKIP;
            end else if (byte_cnt == 6'd33) begin
              of_lookup_req <= 1'b1;
              tmo_cnt       <= 8'd0;
              state         <= S_REQ;
            end
          end
        end

        S_REQ: begin
          // a new frame arriving while the lookup is pending cannot be serviced
          if (rx_dv && !rx_dv_q && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
          tmo_cnt <= tmo_nxt;
          if (of_lookup_ack) begin
            of_lookup_req <= 1'b0;
            res_valid     <= 1'b1;
            res_drop      <= of_lookup_err;
            res_fwd_port  <= of_lookup_err ? 4'd0 : of_lookup_fwd_port;
            state         <= rx_dv ? S_SKIP : S_IDLE;
          end else if (tmo_nxt == TIMEOUT) begin
            of_lookup_req <= 1'b0;
            res_valid     <= 1'b1;
            res_drop      <= 1'b1;
            res_timeout   <= 1'b1;
            state         <= rx_dv ? S_SKIP : S_IDLE;
          end
        end

        S_SKIP: begin
          if (!rx_dv) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_of_key_builder.sv
// Directed bench for of_key_builder: forward, err, ARP, fragment, timeout,
// ack-at-expiry and asynchronous reset during a pending lookup.
module tb_of_key_builder;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic         rx_dv = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         of_lookup_req;
  logic [115:0] of_lookup_data;
  logic         of_lookup_ack = 1'b0;
  logic         of_lookup_err = 1'b0;
  logic [3:0]   of_lookup_fwd_port = 4'd0;
  logic         res_valid;
  logic [3:0]   res_fwd_port;
  logic         res_drop;
  logic         res_timeout;
  logic [15:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] frm [0:63];

  localparam logic [115:0] KEY1 = {4'h1, 48'h406c8f37f1f8, 32'h0A0000C8, 32'h0A000002};

  of_key_builder #(.INGRESS_PORT(4'h1), .TIMEOUT(8'd32)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_dv(rx_dv), .rx_data(rx_data),
    .of_lookup_req(of_lookup_req), .of_lookup_data(of_lookup_data),
    .of_lookup_ack(of_lookup_ack), .of_lookup_err(of_lookup_err),
    .of_lookup_fwd_port(of_lookup_fwd_port), .res_valid(res_valid),
    .res_fwd_port(res_fwd_port), .res_drop(res_drop), .res_timeout(res_timeout),
    .drop_cnt(drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic build_frame(input logic [31:0] dip, input logic [7:0] et_lo);
    logic [47:0] smac;
    logic [31:0] sip;
    smac = 48'h406c8f37f1f8;
    sip  = 32'h0A0000C8;
    for (int i = 0; i < 64; i++) frm[i] = 8'h00;
    for (int i = 0; i < 6; i++) frm[i] = 8'hFF;
    for (int k = 0; k < 6; k++) frm[6+k] = smac[47-8*k -: 8];
    frm[12] = 8'h08;
    frm[13] = et_lo;
    frm[14] = 8'h45;
    for (int k = 0; k < 4; k++) frm[26+k] = sip[31-8*k -: 8];
    for (int k = 0; k < 4; k++) frm[30+k] = dip[31-8*k -: 8];
  endtask

  task automatic send_bytes(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      rx_dv   = 1'b1;
      rx_data = frm[i];
      tick();
    end
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({of_lookup_req, of_lookup_data, res_valid, res_fwd_port, res_drop, res_timeout, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b data=%h valid=%b fwd=%h drop=%b tmo=%b cnt=%0d, want all 0",
               of_lookup_req, of_lookup_data, res_valid, res_fwd_port, res_drop, res_timeout, drop_cnt);
    end
    sys_rst = 1'b0;
    tick();
    checks++;
    if (of_lookup_data !== {4'h1, 112'd0}) begin
      errors++;
      $display("FAIL reset_port_field: got %h want %h", of_lookup_data, {4'h1, 112'd0});
    end
  endtask

  task automatic test_ipv4_fwd(input logic [3:0] fwd);
    build_frame(32'h0A000002, 8'h00);
    send_bytes(0, 32);
    checks++;
    if (of_lookup_req !== 1'b0) begin
      errors++;
      $display("FAIL fwd_req_early: got %b want 0", of_lookup_req);
    end
    send_bytes(33, 33);
    rx_dv = 1'b0;
    checks++;
    if (of_lookup_req !== 1'b1) begin
      errors++;
      $display("FAIL fwd_req_latency: got %b want 1", of_lookup_req);
    end
    checks++;
    if (of_lookup_data !== KEY1) begin
      errors++;
      $display("FAIL fwd_key: got %h want %h", of_lookup_data, KEY1);
    end
    tick();
    checks++;
    if ({of_lookup_req, res_valid, of_lookup_data} !== {1'b1, 1'b0, KEY1}) begin
      errors++;
      $display("FAIL fwd_req_hold: got req=%b valid=%b data=%h want req=1 valid=0 stable key",
               of_lookup_req, res_valid, of_lookup_data);
    end
    of_lookup_ack = 1'b1;
    of_lookup_fwd_port = fwd;
    tick();
    of_lookup_ack = 1'b0;
    of_lookup_fwd_port = 4'd0;
    checks++;
    if ({of_lookup_req, res_valid, res_fwd_port, res_drop, res_timeout} !== {1'b0, 1'b1, fwd, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fwd_result: got req=%b valid=%b fwd=%b drop=%b tmo=%b want req=0 valid=1 fwd=%b drop=0 tmo=0",
               of_lookup_req, res_valid, res_fwd_port, res_drop, res_timeout, fwd);
    end
    tick();
    checks++;
    if ({res_valid, res_fwd_port, res_drop, of_lookup_req} !== 7'd0) begin
      errors++;
      $display("FAIL fwd_pulse_end: got valid=%b fwd=%b drop=%b req=%b want all 0",
               res_valid, res_fwd_port, res_drop, of_lookup_req);
    end
  endtask

  task automatic test_ack_err;
    build_frame(32'h0A000009, 8'h00);
    send_bytes(0, 33);
    rx_dv = 1'b0;
    checks++;
    if (of_lookup_data[31:0] !== 32'h0A000009) begin
      errors++;
      $display("FAIL err_dst_ip: got %h want 0a000009", of_lookup_data[31:0]);
    end
    of_lookup_ack = 1'b1;
    of_lookup_err = 1'b1;
    of_lookup_fwd_port = 4'hF;
    tick();
    of_lookup_ack = 1'b0;
    of_lookup_err = 1'b0;
    of_lookup_fwd_port = 4'd0;
    checks++;
    if ({of_lookup_req, res_valid, res_fwd_port, res_drop, res_timeout} !== {1'b0, 1'b1, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL err_result: got req=%b valid=%b fwd=%b drop=%b tmo=%b want req=0 valid=1 fwd=0 drop=1 tmo=0",
               of_lookup_req, res_valid, res_fwd_port, res_drop, res_timeout);
    end
    tick();
  endtask

  task automatic test_arp;
    logic seen;
    build_frame(32'h0A000002, 8'h06);
    send_bytes(0, 12);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL arp_early_valid: got %b want 0", res_valid);
    end
    send_bytes(13, 13);
    checks++;
    if ({res_valid, res_drop, res_timeout, of_lookup_req} !== 4'b1100) begin
      errors++;
      $display("FAIL arp_drop: got valid=%b drop=%b tmo=%b req=%b want 1 1 0 0",
               res_valid, res_drop, res_timeout, of_lookup_req);
    end
    seen = 1'b0;
    for (int i = 14; i < 60; i++) begin
      rx_dv = 1'b1;
      rx_data = frm[i];
      tick();
      if (of_lookup_req || res_valid) seen = 1'b1;
    end
    rx_dv = 1'b0;
    tick();
    if (of_lookup_req || res_valid) seen = 1'b1;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL arp_skip_quiet: got activity=%b want 0", seen);
    end
  endtask

  task automatic test_ack_outside;
    of_lookup_ack = 1'b1;
    of_lookup_fwd_port = 4'h3;
    tick();
    of_lookup_ack = 1'b0;
    of_lookup_fwd_port = 4'd0;
    checks++;
    if ({res_valid, of_lookup_req} !== 2'b00) begin
      errors++;
      $display("FAIL idle_ack_ignored: got valid=%b req=%b want 0 0", res_valid, of_lookup_req);
    end
  endtask

  task automatic test_fragment;
    build_frame(32'h0A000002, 8'h00);
    send_bytes(0, 29);
    checks++;
    if ({res_valid, of_lookup_req} !== 2'b00) begin
      errors++;
      $display("FAIL frag_mid: got valid=%b req=%b want 0 0", res_valid, of_lookup_req);
    end
    rx_dv = 1'b0;
    tick();
    checks++;
    if ({res_valid, res_drop, res_timeout, res_fwd_port, of_lookup_req} !== {1'b1, 1'b1, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL frag_drop: got valid=%b drop=%b tmo=%b fwd=%b req=%b want 1 1 0 0000 0",
               res_valid, res_drop, res_timeout, res_fwd_port, of_lookup_req);
    end
    tick();
    checks++;
    if ({res_valid, of_lookup_req} !== 2'b00) begin
      errors++;
      $display("FAIL frag_after: got valid=%b req=%b want 0 0", res_valid, of_lookup_req);
    end
  endtask

  task automatic test_timeout;
    int cnt;
    build_frame(32'h0A000002, 8'h00);
    send_bytes(0, 33);
    rx_dv = 1'b0;
    cnt = 0;
    while (of_lookup_req === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 5) rx_dv = 1'b1;
      if (cnt == 15) rx_dv = 1'b0;
      rx_data = 8'hAA;
      tick();
    end
    checks++;
    if (cnt != 32) begin
      errors++;
      $display("FAIL tmo_req_cycles: got %0d want 32", cnt);
    end
    checks++;
    if ({res_valid, res_drop, res_timeout, res_fwd_port} !== {1'b1, 1'b1, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL tmo_result: got valid=%b drop=%b tmo=%b fwd=%b want 1 1 1 0000",
               res_valid, res_drop, res_timeout, res_fwd_port);
    end
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL tmo_drop_cnt: got %0d want 1", drop_cnt);
    end
    tick();
    checks++;
    if ({res_valid, res_timeout, of_lookup_req} !== 3'b000) begin
      errors++;
      $display("FAIL tmo_pulse_end: got valid=%b tmo=%b req=%b want 0 0 0", res_valid, res_timeout, of_lookup_req);
    end
  endtask

  task automatic test_ack_at_expiry;
    int cnt;
    build_frame(32'h0A000002, 8'h00);
    send_bytes(0, 33);
    rx_dv = 1'b0;
    cnt = 0;
    while (of_lookup_req === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 32) begin
        of_lookup_ack = 1'b1;
        of_lookup_fwd_port = 4'b0100;
      end
      tick();
      of_lookup_ack = 1'b0;
      of_lookup_fwd_port = 4'd0;
    end
    checks++;
    if (cnt != 32) begin
      errors++;
      $display("FAIL expiry_req_cycles: got %0d want 32", cnt);
    end
    checks++;
    if ({res_valid, res_fwd_port, res_drop, res_timeout} !== {1'b1, 4'b0100, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL expiry_ack_wins: got valid=%b fwd=%b drop=%b tmo=%b want 1 0100 0 0",
               res_valid, res_fwd_port, res_drop, res_timeout);
    end
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL expiry_drop_cnt: got %0d want 1", drop_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_req;
    build_frame(32'h0A000002, 8'h00);
    send_bytes(0, 33);
    rx_dv = 1'b0;
    tick();
    checks++;
    if (of_lookup_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_req: got %b want 1", of_lookup_req);
    end
    #2;
    sys_rst = 1'b1;
    #1;
    checks++;
    if ({of_lookup_req, of_lookup_data, res_valid, res_fwd_port, res_drop, res_timeout, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_async: got req=%b data=%h valid=%b cnt=%0d want all 0",
               of_lookup_req, of_lookup_data, res_valid, drop_cnt);
    end
    tick();
    sys_rst = 1'b0;
    tick();
    test_ipv4_fwd(4'b1000);
  endtask

  initial begin
    test_reset();
    test_ipv4_fwd(4'b0010);
    test_ack_err();
    test_arp();
    test_ack_outside();
    test_fragment();
    test_timeout();
    test_ack_at_expiry();
    test_reset_mid_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
